// File: rtl/branch_predictor_pkg.sv
// Shared branch-prediction types: 2-bit saturating counter encoding and its reset value.
package rv32i_types;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_ctr_t;

    localparam bht_ctr_t BHT_RESET = WNT;

endpackage

// File: rtl/branch_predictor_bht_sat_ctr.sv
// Next-state function of one 2-bit saturating direction counter.
module bht_sat_ctr
    import rv32i_types::*;
(
    input  bht_ctr_t ctr_i,
    input  logic     taken_i,
    output bht_ctr_t ctr_o
);

    // Step toward ST on taken, toward SNT on not-taken, holding at the ends.
    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            case (ctr_i)
                SNT:     ctr_o = WNT;
                WNT:     ctr_o = WT;
                WT:      ctr_o = ST;
                ST:      ctr_o = ST;
                default: ctr_o = BHT_RESET;
            endcase
        end else begin
            case (ctr_i)
                SNT:     ctr_o = SNT;
                WNT:     ctr_o = SNT;
                WT:      ctr_o = WNT;
                ST:      ctr_o = WT;
                default: ctr_o = BHT_RESET;
            endcase
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Gshare direction predictor: PC xor global history indexes a table of 2-bit counters,
// trained by execute-stage resolutions, with speculative history repaired on mispredict.
module branch_predictor
    import rv32i_types::*;
#(
    parameter int IDX_W = 6,
    parameter int GHR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pred_valid,
    input  logic [31:0]       pred_pc,
    output logic              pred_taken,
    output logic [GHR_W-1:0]  pred_ghr,
    input  logic              res_valid,
    input  logic [31:0]       res_pc,
    input  logic              res_br_en,
    input  logic              res_pred_taken,
    input  logic [GHR_W-1:0]  res_ghr,
    output logic              mispredict,
    output logic [31:0]       perf_branches,
    output logic [31:0]       perf_mispredicts
);

    localparam int ENTRIES = 1 << IDX_W;

    bht_ctr_t           table_q [ENTRIES];
    bht_ctr_t           table_d [ENTRIES];
    logic [GHR_W-1:0]   ghr_q, ghr_d;
    logic               mispredict_q, mispredict_d;
    logic [31:0]        perf_br_q, perf_br_d;
    logic [31:0]        perf_mp_q, perf_mp_d;

    logic [IDX_W-1:0]   pred_idx_s;
    logic [IDX_W-1:0]   upd_idx_s;
    logic               mismatch_s;
    bht_ctr_t           upd_next_s;
    logic               unused_s;

    assign pred_idx_s = pred_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
    assign upd_idx_s  = res_pc[IDX_W+1:2] ^ IDX_W'(res_ghr);
    assign mismatch_s = res_valid && (res_br_en != res_pred_taken);
    assign unused_s   = ^{pred_pc[31:IDX_W+2], pred_pc[1:0], res_pc[31:IDX_W+2], res_pc[1:0]};

    assign pred_taken       = table_q[pred_idx_s][1];
    assign pred_ghr         = ghr_q;
    assign mispredict       = mispredict_q;
    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mp_q;

    bht_sat_ctr u_sat_ctr (
        .ctr_i   (table_q[upd_idx_s]),
        .taken_i (res_br_en),
        .ctr_o   (upd_next_s)
    );

    // Next-state for table, history, mispredict pulse and perf counters.
    always_comb begin
        table_d      = table_q;
        ghr_d        = ghr_q;
        mispredict_d = mismatch_s;
        perf_br_d    = perf_br_q;
        perf_mp_d    = perf_mp_q;
        if (res_valid) begin
            table_d[upd_idx_s] = upd_next_s;
            if (perf_br_q != 32'hFFFF_FFFF) begin
                perf_br_d = perf_br_q + 32'd1;
            end else begin
                perf_br_d = perf_br_q;
            end
        end else begin
            table_d = table_q;
        end
        // Repair wins over the speculative shift: fetch is being flushed anyway.
        if (mismatch_s) begin
            ghr_d = {res_ghr[GHR_W-2:0], res_br_en};
            if (perf_mp_q != 32'hFFFF_FFFF) begin
                perf_mp_d = perf_mp_q + 32'd1;
            end else begin
                perf_mp_d = perf_mp_q;
            end
        end else if (pred_valid) begin
            ghr_d = {ghr_q[GHR_W-2:0], pred_taken};
        end else begin
            ghr_d = ghr_q;
        end
    end

    // State registers; reset reinitialises every counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= BHT_RESET;
            end
            ghr_q        <= '0;
            mispredict_q <= 1'b0;
            perf_br_q    <= 32'd0;
            perf_mp_q    <= 32'd0;
        end else begin
            table_q      <= table_d;
            ghr_q        <= ghr_d;
            mispredict_q <= mispredict_d;
            perf_br_q    <= perf_br_d;
            perf_mp_q    <= perf_mp_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for the gshare branch predictor.
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [3:0]  pred_ghr;
    logic        res_valid;
    logic [31:0] res_pc;
    logic        res_br_en;
    logic        res_pred_taken;
    logic [3:0]  res_ghr;
    logic        mispredict;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    int checks;
    int failures;

    branch_predictor #(.IDX_W(6), .GHR_W(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pred_valid       (pred_valid),
        .pred_pc          (pred_pc),
        .pred_taken       (pred_taken),
        .pred_ghr         (pred_ghr),
        .res_valid        (res_valid),
        .res_pc           (res_pc),
        .res_br_en        (res_br_en),
        .res_pred_taken   (res_pred_taken),
        .res_ghr          (res_ghr),
        .mispredict       (mispredict),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [3:0] gh, input logic br, input logic pt);
        res_valid      = 1'b1;
        res_pc         = pc;
        res_ghr        = gh;
        res_br_en      = br;
        res_pred_taken = pt;
        @(negedge clk);
        res_valid      = 1'b0;
    endtask

    task automatic lookup_shift(input logic [31:0] pc);
        pred_valid = 1'b1;
        pred_pc    = pc;
        @(negedge clk);
        pred_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        pred_valid = 1'b0;
        pred_pc = 32'h0;
        res_valid = 1'b0;
        res_pc = 32'h0;
        res_br_en = 1'b0;
        res_pred_taken = 1'b0;
        res_ghr = 4'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        pred_pc = 32'h40;
        #1;
        chk("rst_pred_taken", 32'(pred_taken), 32'd0);
        chk("rst_pred_ghr", 32'(pred_ghr), 32'h0);
        chk("rst_mispredict", 32'(mispredict), 32'd0);
        chk("rst_perf_br", perf_branches, 32'd0);
        chk("rst_perf_mp", perf_mispredicts, 32'd0);

        // Training idx 0 to ST
        resolve(32'h100, 4'h0, 1'b1, 1'b1);
        chk("train1_mispredict", 32'(mispredict), 32'd0);
        resolve(32'h100, 4'h0, 1'b1, 1'b1);
        chk("train2_mispredict", 32'(mispredict), 32'd0);
        pred_pc = 32'h100;
        #1;
        chk("train_pred_taken", 32'(pred_taken), 32'd1);
        chk("train_perf_br", perf_branches, 32'd2);
        chk("train_ghr_hold", 32'(pred_ghr), 32'h0);

        // Saturation at ST then down to SNT
        resolve(32'h100, 4'h0, 1'b1, 1'b1);
        resolve(32'h100, 4'h0, 1'b0, 1'b0);
        chk("sat_st_then_dec", 32'(pred_taken), 32'd1);
        resolve(32'h100, 4'h0, 1'b0, 1'b0);
        chk("dec_to_wnt", 32'(pred_taken), 32'd0);
        resolve(32'h100, 4'h0, 1'b0, 1'b0);
        resolve(32'h100, 4'h0, 1'b0, 1'b0);
        chk("sat_snt", 32'(pred_taken), 32'd0);
        resolve(32'h100, 4'h0, 1'b1, 1'b1);
        resolve(32'h100, 4'h0, 1'b1, 1'b1);
        chk("snt_held_then_inc2", 32'(pred_taken), 32'd1);
        chk("sat_perf_br", perf_branches, 32'd9);
        chk("sat_perf_mp", perf_mispredicts, 32'd0);

        // Mispredict repair beats concurrent lookup shift
        pred_valid = 1'b1;
        pred_pc = 32'h40;
        resolve(32'h08, 4'b0101, 1'b1, 1'b0);
        pred_valid = 1'b0;
        #1;
        chk("mp_ghr_repair", 32'(pred_ghr), 32'hB);
        chk("mp_pulse", 32'(mispredict), 32'd1);
        chk("mp_perf_mp", perf_mispredicts, 32'd1);
        chk("mp_perf_br", perf_branches, 32'd10);
        @(negedge clk);
        chk("mp_pulse_end", 32'(mispredict), 32'd0);

        // Back-to-back mispredicts, second repairs ghr to 0
        resolve(32'h0, 4'b0011, 1'b1, 1'b0);
        chk("b2b_pulse1", 32'(mispredict), 32'd1);
        chk("b2b_ghr1", 32'(pred_ghr), 32'h7);
        resolve(32'h0, 4'b0000, 1'b0, 1'b1);
        chk("b2b_pulse2", 32'(mispredict), 32'd1);
        chk("b2b_ghr2", 32'(pred_ghr), 32'h0);
        @(negedge clk);
        chk("b2b_pulse_end", 32'(mispredict), 32'd0);
        chk("b2b_perf_mp", perf_mispredicts, 32'd3);

        // Same-index read and write: no bypass
        pred_pc = 32'h14;
        res_valid = 1'b1;
        res_pc = 32'h14;
        res_ghr = 4'h0;
        res_br_en = 1'b1;
        res_pred_taken = 1'b1;
        #1;
        chk("rw_same_cycle", 32'(pred_taken), 32'd0);
        @(negedge clk);
        res_valid = 1'b0;
        #1;
        chk("rw_next_cycle", 32'(pred_taken), 32'd1);
        chk("rw_perf_br", perf_branches, 32'd13);

        // Train idx 0 to ST, shift ghr to 4'hA via predictions 1,0,1,0
        resolve(32'h100, 4'h0, 1'b1, 1'b1);
        resolve(32'h100, 4'h0, 1'b1, 1'b1);
        lookup_shift(32'h100);
        lookup_shift(32'h20);
        lookup_shift(32'h1C);
        lookup_shift(32'h20);
        pred_pc = 32'h28;
        #1;
        chk("pre_rst_ghr", 32'(pred_ghr), 32'hA);
        chk("pre_rst_idx0_st", 32'(pred_taken), 32'd1);

        // Asynchronous reset between edges
        #1;
        rst_n = 1'b0;
        pred_pc = 32'h100;
        #1;
        chk("arst_ghr", 32'(pred_ghr), 32'h0);
        chk("arst_pred_taken", 32'(pred_taken), 32'd0);
        chk("arst_perf_br", perf_branches, 32'd0);
        chk("arst_perf_mp", perf_mispredicts, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pred_pc = 32'h14;
        #1;
        chk("arst_idx5_reinit", 32'(pred_taken), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Gshare direction predictor: the consumer end of the branch-outcome interface driven by the execute-stage comparator's br_en.
- Fetch queries a taken/not-taken prediction per PC. Execute returns the resolved outcome, which trains a table of 2-bit saturating counters and repairs speculative global history on a mispredict.
- Sits between fetch (lookup port) and execute (resolve port); its registered mispredict pulse feeds pipeline flush control.

Parameters:
- IDX_W, 6, log2 of counter-table entries (64 entries).
- GHR_W, 4, global history bits; legal range 2..IDX_W.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset.
- pred_valid  in  1  fetch lookup valid this cycle.
- pred_pc  in  32  fetch PC.
- pred_taken  out  1  prediction for pred_pc, same cycle (combinational).
- pred_ghr  out  GHR_W  history snapshot used for this lookup; carried down the pipeline.
- res_valid  in  1  resolved conditional branch this cycle.
- res_pc  in  32  PC of resolved branch.
- res_br_en  in  1  actual outcome (comparator br_en).
- res_pred_taken  in  1  prediction originally given for this branch.
- res_ghr  in  GHR_W  pred_ghr snapshot carried with this branch.
- mispredict  out  1  registered pulse: resolution mismatch.
- perf_branches  out  32  resolved-branch count.
- perf_mispredicts  out  32  mispredict count.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- On reset:
  - All counters = WNT (2'b01); ghr = 0.
  - mispredict = 0; perf counters = 0.
  - pred_taken is combinational, so after reset it reads 0.
- Reset deassertion mid-stream: the table is fully reinitialised and no in-flight update survives.
- Indexing (pred_*):
  - lookup index = pred_pc[IDX_W+1:2] XOR zero-extended ghr.
  - pred_taken = counter[idx][1]; pred_ghr = ghr.
  - Output is valid regardless of pred_valid.
- Update index (res_*): res_pc[IDX_W+1:2] XOR zero-extended res_ghr.
- Counter update, at the clock edge when res_valid = 1:
  - res_br_en = 1: increment, saturating at ST (11).
  - res_br_en = 0: decrement, saturating at SNT (00).
- Same-index read/write in one cycle: the lookup returns the pre-update value (no bypass). The new value is visible from the next cycle.
- GHR update, in priority order:
  1. res_valid and res_br_en != res_pred_taken: ghr <= {res_ghr[GHR_W-2:0], res_br_en} (repair). Any concurrent pred_valid shift is discarded, because fetch is being flushed.
  2. Otherwise, pred_valid: ghr <= {ghr[GHR_W-2:0], pred_taken}.
  3. Otherwise: hold.
- mispredict:
  - Registered: 1 on the cycle after a mismatching res_valid, else 0.
  - Back-to-back mismatches give back-to-back pulses.
- Perf counters:
  - perf_branches += 1 per res_valid.
  - perf_mispredicts += 1 per mismatch.
  - Both saturate at 32'hFFFF_FFFF (no wrap).
- res_valid = 0: res_* inputs are ignored entirely.

Decomposition:
- rv32i_types gains:
  - enum bht_ctr_t (SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11);
  - constant BHT_RESET = WNT.
- One sub-module: bht_sat_ctr, a combinational next-state function (current bht_ctr_t, taken -> next bht_ctr_t), instantiated on the update path.
- Table and GHR flops live in branch_predictor.

Test Plan:
- Reset: rst_n low, release; pred_pc = 0x40 -> pred_taken = 0, pred_ghr = 4'h0, mispredict = 0, perf_* = 0.
- Training:
  - Two res_valid cycles, res_pc = 0x100, res_ghr = 0, res_br_en = 1, res_pred_taken = 1.
  - Result: idx 0 counter goes 01 -> 10 -> 11. pred_pc = 0x100 (ghr = 0) -> pred_taken = 1; no mispredict pulses; perf_branches = 2.
- Saturation: a third taken update at idx 0 -> stays ST. Then four not-taken updates -> 11 -> 10 -> 01 -> 00 -> 00; pred_taken = 0.
- Mispredict with concurrent lookup:
  - Same cycle: res_valid, res_ghr = 4'b0101, res_br_en = 1, res_pred_taken = 0, plus pred_valid.
  - Next cycle: ghr = 4'b1011, mispredict = 1, perf_mispredicts = 1.
  - Cycle after: mispredict = 0.
- Same-index read/write:
  - Counter at idx 5 = WNT; pred_pc = 0x14 and taken update at res_pc = 0x14 in the same cycle, ghr = res_ghr = 0.
  - That cycle pred_taken = 0; next cycle pred_taken = 1.
- Async reset mid-operation: after training idx 0 to ST and shifting ghr to 4'hA, pulse rst_n low between clock edges -> immediately ghr = 0, pred_taken(0x100) = 0, perf_* = 0.
